pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 133 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - rPLL reset/lock sequencer releasing a synchronous system reset after stable lock
// Optional build macro: PLL_SEQ_FAILCNT_EN (builds the saturating fail_count register; otherwise fail_count is 0)
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 20
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] fail_count
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts, so each state's expiry test is a single compare against the shared counter.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] count;
  logic [1:0]       lock_sync;
  logic             lock_s;
  logic             fail_inc;

  assign lock_s = lock_sync[1];

  // Two-flop synchronizer bringing the asynchronous PLL lock into the clkin domain.
  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], lock};
    end
  end

  // State register and shared counter; the counter restarts from 0 on every state change.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state <= PLL_RST;
      count <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // Next-state decode; lock-drop tests are placed ahead of counter expiry so they win in the same cycle.
  always_comb begin
    state_n  = state;
    fail_inc = 1'b0;
    case (state)
      PLL_RST: begin
        if (count == RST_LAST) begin
          state_n = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = STABLE;
        end else if (count == TIMEOUT_LAST) begin
          state_n  = PLL_RST;
          fail_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
        end else if (count == STABLE_LAST) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_n  = PLL_RST;
          fail_inc = 1'b1;
        end
      end
      default: begin
        state_n = PLL_RST;
      end
    endcase
  end

  // Outputs decoded from the next state so they update on the same edge as the state register.
  always_ff @(posedge clkin) begin
    if (reset) begin
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      pll_reset <= (state_n == PLL_RST);
      sys_reset <= (state_n != RUN);
      ready     <= (state_n == RUN);
    end
  end

`ifdef PLL_SEQ_FAILCNT_EN
  logic [7:0] fail_cnt_q;

  // Saturating count of lock timeouts and lock losses; only the block reset clears it.
  always_ff @(posedge clkin) begin
    if (reset) begin
      fail_cnt_q <= 8'd0;
    end else if (fail_inc && (fail_cnt_q != 8'hFF)) begin
      fail_cnt_q <= fail_cnt_q + 8'd1;
    end
  end

  assign fail_count = fail_cnt_q;
`else
  logic unused_fail_inc;

  assign unused_fail_inc = fail_inc;
  assign fail_count      = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  logic       clkin;
  logic       reset;
  logic       lock;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic [7:0] fail_count;

  int          n_checks;
  int          n_pass;
  string       sb_name[$];
  int          sb_val[$];
  string       nm;
  int          ev;
  logic [31:0] obs;

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .CNT_W        (20)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .lock      (lock),
    .pll_reset (pll_reset),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fail_count(fail_count)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Expected fail_count after n failure events.
  function automatic int exp_fc(input int n);
`ifdef PLL_SEQ_FAILCNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic push_exp(input string name, input int val);
    sb_name.push_back(name);
    sb_val.push_back(val);
  endtask

  // Holds reset for 3 edges and releases it at a falling edge (sample index 0).
  task automatic apply_reset();
    reset = 1'b1;
    lock  = 1'b0;
    repeat (3) @(negedge clkin);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lock  = 1'b0;
    repeat (2) @(negedge clkin);
    push_exp("rst_pll_reset", 1);
    push_exp("rst_sys_reset", 1);
    push_exp("rst_ready", 0);
    push_exp("rst_fail_count", 0);
    obs = 32'(pll_reset);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(sys_reset);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(ready);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(fail_count);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
  endtask

  task automatic test_startup();
    int w;
    int lat;
    apply_reset();
    push_exp("startup_pll_width", 4);
    w = 0;
    while (pll_reset === 1'b1 && w < 20) begin
      w++;
      @(negedge clkin);
    end
    obs = 32'(w);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    repeat (10 - w) @(negedge clkin);
    lock = 1'b1;
    push_exp("startup_ready_latency", 11);
    push_exp("startup_sys_reset", 0);
    push_exp("startup_fail_count", 0);
    lat = 0;
    while (ready !== 1'b1 && lat < 100) begin
      @(negedge clkin);
      lat++;
    end
    obs = 32'(lat);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(sys_reset);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(fail_count);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
  endtask

  task automatic test_timeout();
    int last_rise;
    int rises;
    logic prev;
    logic any_ready;
    apply_reset();
    last_rise = 0;
    rises     = 0;
    prev      = 1'b1;
    any_ready = 1'b0;
    for (int s = 1; s <= 113; s++) begin
      @(negedge clkin);
      any_ready = any_ready | ready;
      if (pll_reset === 1'b1 && prev === 1'b0) begin
        rises++;
        push_exp("timeout_period", 36);
        push_exp("timeout_fail_count", exp_fc(rises));
        obs = 32'(s - last_rise);
        nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
        if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
        obs = 32'(fail_count);
        nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
        if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
        last_rise = s;
      end
      if (pll_reset === 1'b0 && prev === 1'b1) begin
        push_exp("timeout_pulse_width", 4);
        obs = 32'(s - last_rise);
        nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
        if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
      end
      prev = pll_reset;
    end
    push_exp("timeout_retries", 3);
    push_exp("timeout_ready_seen", 0);
    obs = 32'(rises);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(any_ready);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
  endtask

  task automatic test_glitch();
    int first_rise;
    logic any_ready;
    apply_reset();
    repeat (10) @(negedge clkin);
    lock = 1'b1;
    repeat (5) @(negedge clkin);
    lock = 1'b0;
    // Back in WAIT_LOCK after edge 18, the retry timeout then fires 32 edges later.
    push_exp("glitch_first_retry", 50);
    push_exp("glitch_ready_seen", 0);
    push_exp("glitch_fail_count", exp_fc(1));
    first_rise = -1;
    any_ready  = 1'b0;
    for (int s = 16; s <= 60; s++) begin
      @(negedge clkin);
      any_ready = any_ready | ready;
      if (pll_reset === 1'b1 && first_rise < 0) first_rise = s;
    end
    obs = 32'(first_rise);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(any_ready);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(fail_count);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int w;
    apply_reset();
    repeat (10) @(negedge clkin);
    lock = 1'b1;
    push_exp("loss_first_ready_latency", 11);
    lat = 0;
    while (ready !== 1'b1 && lat < 100) begin
      @(negedge clkin);
      lat++;
    end
    obs = 32'(lat);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    repeat (4) @(negedge clkin);
    lock = 1'b0;
    push_exp("loss_sys_reset_t2", 0);
    push_exp("loss_sys_reset_t3", 1);
    push_exp("loss_pll_reset_t3", 1);
    push_exp("loss_fail_count", exp_fc(1));
    push_exp("loss_pll_width", 4);
    push_exp("loss_ready_relock", 9);
    @(negedge clkin);
    lock = 1'b1;
    @(negedge clkin);
    obs = 32'(sys_reset);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    @(negedge clkin);
    obs = 32'(sys_reset);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(pll_reset);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(fail_count);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    w = 0;
    while (pll_reset === 1'b1 && w < 20) begin
      w++;
      @(negedge clkin);
    end
    obs = 32'(w);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    lat = 0;
    while (ready !== 1'b1 && lat < 100) begin
      @(negedge clkin);
      lat++;
    end
    obs = 32'(lat);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
  endtask

  task automatic test_saturation();
    int w;
    apply_reset();
    push_exp("sat_fail_count_254", exp_fc(254));
    push_exp("sat_fail_count_260", exp_fc(260));
    for (int s = 1; s <= 36 * 260 + 1; s++) begin
      @(negedge clkin);
      if (s == 36 * 254 + 1 || s == 36 * 260 + 1) begin
        obs = 32'(fail_count);
        nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
        if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
      end
    end
    repeat (10) @(negedge clkin);
    reset = 1'b1;
    push_exp("midreset_fail_count", 0);
    push_exp("midreset_pll_reset", 1);
    push_exp("midreset_ready", 0);
    push_exp("midreset_pll_width", 4);
    @(negedge clkin);
    obs = 32'(fail_count);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(pll_reset);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    obs = 32'(ready);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
    reset = 1'b0;
    w = 0;
    while (pll_reset === 1'b1 && w < 20) begin
      w++;
      @(negedge clkin);
    end
    obs = 32'(w);
    nm = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== 32'(ev)) $display("FAIL %s: got %0d, expected %0d", nm, obs, ev); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    lock     = 1'b0;
    test_reset();
    test_startup();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
